apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Upstream APB requester feeding the APB slave: converts a simple valid/ready command
//  port into APB3 SETUP/ACCESS transfers, waits out slave wait states and returns
//  PRDATA/PSLVERR on a one-cycle response strobe. Single outstanding transfer.
// PARAMETERS
//  ADDR_W          32   PADDR / cmd_addr width
//  DATA_W          32   PWDATA / PRDATA width
//  TIMEOUT_CYCLES  16   max ACCESS cycles without PREADY (used only with APB_TIMEOUT_EN)
// PORTS
//  PCLK         in   1       clock, all logic on rising edge
//  PRESET       in   1       synchronous reset, active-high
//  cmd_valid    in   1       command request
//  cmd_ready    out  1       command accepted when valid&ready at PCLK edge
//  cmd_write    in   1       1=write, 0=read
//  cmd_addr     in   ADDR_W  byte address
//  cmd_wdata    in   DATA_W  write data
//  rsp_valid    out  1       one-cycle response strobe
//  rsp_rdata    out  DATA_W  read data (0 for writes)
//  rsp_err      out  1       PSLVERR captured, or timeout
//  rsp_timeout  out  1       transfer aborted by watchdog
//  PSELx        out  1       APB select
//  PENABLE      out  1       APB enable
//  PWRITE       out  1       APB direction
//  PADDR        out  ADDR_W  APB address
//  PWDATA       out  DATA_W  APB write data
//  PRDATA       in   DATA_W  APB read data
//  PREADY       in   1       APB ready (registered by slave)
//  PSLVERR      in   1       APB error, valid only with PREADY
// BEHAVIOUR
//  - Reset (PRESET=1 at edge): state=IDLE; PSELx/PENABLE/PWRITE/rsp_* = 0; PADDR/PWDATA = 0;
//    wait counter = 0. Reset mid-transfer aborts it: PSELx/PENABLE low after that edge, no rsp.
//  - cmd_ready = (state==IDLE), combinational; 1 immediately after reset.
//  - FSM IDLE -> SETUP on cmd_valid&cmd_ready: latch addr/wdata/write into PADDR/PWDATA/PWRITE,
//    PSELx=1, PENABLE=0.
//  - SETUP -> ACCESS unconditionally after 1 cycle: PENABLE=1, counter cleared.
//  - ACCESS: PREADY sampled 1 -> capture rsp_rdata=PWRITE?0:PRDATA, rsp_err=PSLVERR,
//    rsp_valid=1 for exactly one cycle; PSELx=PENABLE=0; -> IDLE. PREADY=0 -> stay, counter+1.
//  - PADDR/PWDATA/PWRITE held stable from SETUP through completion; never change in ACCESS.
//  - Minimum latency: accept edge N, SETUP N..N+1, ACCESS from N+1; PREADY seen high at edge
//    N+1+k -> rsp_valid high cycle after that edge. Back-to-back: one IDLE cycle between transfers.
//  - cmd_valid while busy ignored (cmd_ready=0); no queueing. rsp_rdata/rsp_err hold until next rsp.
//  - PSLVERR ignored unless PREADY=1. PREADY in SETUP ignored.
//  - Counter saturates at TIMEOUT_CYCLES; width = $clog2(TIMEOUT_CYCLES+1).
// CONFIGURATION
//  APB_TIMEOUT_EN defined: in ACCESS, if counter reaches TIMEOUT_CYCLES with PREADY still 0,
//    drop PSELx/PENABLE, pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0, -> IDLE.
//    PREADY=1 on the same edge the limit is reached wins (normal completion).
//  APB_TIMEOUT_EN undefined: no watchdog, ACCESS waits indefinitely; rsp_timeout tied 0.
// TESTING
//  1 write 0x0000_0010 data 0xDEAD_BEEF, slave 0 waits -> PSELx 1 then PENABLE 1, rsp_valid, rsp_err=0
//  2 read 0x0000_0013 after write 0xCAFE_0001 there, slave 3 waits -> PENABLE held 4+ cycles,
//    PADDR stable, rsp_rdata=0xCAFE_0001
//  3 read 0x0000_1000 (beyond slave memory) -> rsp_err=1, rsp_valid one cycle, FSM back to IDLE
//  4 cmd_valid held high for 3 commands -> cmd_ready low while busy, exactly 3 rsp_valid pulses in order
//  5 PRESET asserted during ACCESS -> PSELx/PENABLE 0 next edge, no rsp_valid, cmd_ready=1
//  6 APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> rsp_timeout=1, rsp_err=1 after 4 ACCESS cycles

Source files
------------

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB3 requester: one transfer at a time, SETUP then ACCESS,
// one-cycle response strobe. Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;

  // Handshake: a command transfers on a PCLK edge where cmd_valid and cmd_ready are both high;
  // cmd_ready is high only in IDLE, so nothing is accepted while a transfer is in flight.
  assign cmd_ready = (state == IDLE);
  assign fsm_state = state;

`ifndef APB_TIMEOUT_EN
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PWRITE  <= cmd_write;
            PSELx   <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
`ifdef APB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          // This edge is the TIMEOUT_CYCLES-th ACCESS cycle without PREADY: abandon the slave.
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            wait_cnt    <= CNT_W'(TIMEOUT_CYCLES);
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end
`endif
          else if (wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small behavioural APB slave (memory, wait states,
// error above 0xFF). Watchdog case runs only when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [1:0]  fsm_state;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  // behavioural slave
  int          wait_n     = 0;
  logic        stall      = 1'b0;
  logic        setup_rdy  = 1'b0;
  logic [3:0]  wcnt       = '0;
  logic [31:0] mem [0:255];
  logic        slv_err;

  assign slv_err = (PADDR >= 32'h100);
  assign PREADY  = !stall && ((setup_rdy && PSELx && !PENABLE) ||
                              (PSELx && PENABLE && (int'(wcnt) == wait_n)));
  assign PSLVERR = PSELx && slv_err;
  assign PRDATA  = slv_err ? 32'hBAD0_BAD0 : mem[PADDR[7:0]];

  always @(posedge PCLK) begin
    if (PSELx && !PENABLE) wcnt <= '0;
    else if (PSELx && PENABLE) wcnt <= wcnt + 4'd1;
    if (PSELx && PENABLE && PREADY && PWRITE && !slv_err) mem[PADDR[7:0]] <= PWDATA;
  end

  // scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge PCLK); @(negedge PCLK);
    cmd_valid = 1'b0;
    chk({tag, "_setup"}, {28'd0, PSELx, PENABLE, PWRITE, cmd_ready}, {28'd0, 1'b1, 1'b0, w, 1'b0});
    chk({tag, "_paddr"}, PADDR, a);
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] a, input logic [31:0] exp_rdata,
                          input logic exp_err, input logic exp_to, input int exp_lat,
                          output int en_cycles);
    int lat = 0;
    int paddr_bad = 0;
    en_cycles = 0;
    do begin
      if (PENABLE) en_cycles++;
      if (PADDR !== a) paddr_bad++;
      @(posedge PCLK); @(negedge PCLK);
      lat++;
    end while (!rsp_valid && lat < 60);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_paddr_stable"}, paddr_bad, 0);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err_to"}, {30'd0, rsp_err, rsp_timeout}, {30'd0, exp_err, exp_to});
    chk({tag, "_bus_idle"}, {29'd0, PSELx, PENABLE, cmd_ready}, 32'd1);
    @(posedge PCLK); @(negedge PCLK);
    chk({tag, "_one_cycle"}, {30'd0, rsp_valid, rsp_err}, {30'd0, 1'b0, exp_err});
    chk({tag, "_hold_idle"}, {rsp_rdata[29:0], fsm_state}, {exp_rdata[29:0], 2'd0});
  endtask

  initial begin
    int en, got, idx, extra;
    logic will_acc;
    logic [31:0] a4 [0:2];
    logic [31:0] d4 [0:2];
    logic        w4 [0:2];
    logic [31:0] e4 [0:2];

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset_outputs", {28'd0, PSELx, PENABLE, PWRITE, rsp_valid},  32'd0);
    chk("reset_paddr_pwdata", PADDR | PWDATA, 32'd0);
    chk("reset_state", {29'd0, cmd_ready, fsm_state}, {29'd0, 1'b1, 2'd0});
    PRESET = 1'b0;
    @(negedge PCLK);

    // 1: zero-wait write
    wait_n = 0;
    issue("t1", 1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("t1_pwdata", PWDATA, 32'hDEAD_BEEF);
    @(posedge PCLK); @(negedge PCLK);
    chk("t1_access", {30'd0, PSELx, PENABLE}, 32'd3);
    wait_rsp("t1", 32'h10, 32'h0, 1'b0, 1'b0, 1, en);

    // 2: write then read with 3 wait states
    issue("t2w", 1'b1, 32'h13, 32'hCAFE_0001);
    wait_rsp("t2w", 32'h13, 32'h0, 1'b0, 1'b0, 2, en);
    wait_n = 3;
    issue("t2r", 1'b0, 32'h13, 32'h0);
    wait_rsp("t2r", 32'h13, 32'hCAFE_0001, 1'b0, 1'b0, 5, en);
    chk("t2r_penable_cycles", en, 4);

    // 3: out-of-range read, PREADY also raised in SETUP (must be ignored), PSLVERR early
    wait_n = 2; setup_rdy = 1'b1;
    issue("t3", 1'b0, 32'h1000, 32'h0);
    wait_rsp("t3", 32'h1000, 32'hBAD0_BAD0, 1'b1, 1'b0, 4, en);
    setup_rdy = 1'b0;

    // 4: cmd_valid held across three commands
    wait_n = 1;
    a4[0] = 32'h10; w4[0] = 1'b0; d4[0] = 32'h0;          e4[0] = 32'hDEAD_BEEF;
    a4[1] = 32'h20; w4[1] = 1'b1; d4[1] = 32'h1234_5678;  e4[1] = 32'h0;
    a4[2] = 32'h20; w4[2] = 1'b0; d4[2] = 32'h0;          e4[2] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) exp_q.push_back(e4[i]);
    idx = 0; got = 0; extra = 0;
    cmd_valid = 1'b1; cmd_write = w4[0]; cmd_addr = a4[0]; cmd_wdata = d4[0];
    for (int c = 0; c < 60 && got < 3; c++) begin
      will_acc = cmd_valid && cmd_ready;
      if (PSELx && cmd_ready) extra++;
      @(posedge PCLK); @(negedge PCLK);
      if (rsp_valid) begin
        got++;
        if (exp_q.size() == 0) chk("t4_extra_rsp", rsp_rdata, 32'hFFFF_FFFF);
        else chk("t4_rsp_order", rsp_rdata, exp_q.pop_front());
      end
      if (will_acc) begin
        idx++;
        if (idx < 3) begin
          cmd_write = w4[idx]; cmd_addr = a4[idx]; cmd_wdata = d4[idx];
        end else cmd_valid = 1'b0;
      end
    end
    repeat (6) begin
      @(posedge PCLK); @(negedge PCLK);
      if (rsp_valid) got++;
    end
    chk("t4_rsp_count", got, 3);
    chk("t4_ready_while_busy", extra, 0);

    // 5: reset during ACCESS
    wait_n = 5;
    issue("t5", 1'b0, 32'h10, 32'h0);
    @(posedge PCLK); @(negedge PCLK);
    chk("t5_in_access", {30'd0, PSELx, PENABLE}, 32'd3);
    PRESET = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    chk("t5_abort", {28'd0, PSELx, PENABLE, rsp_valid, cmd_ready}, 32'd1);
    chk("t5_paddr_cleared", PADDR, 32'd0);
    PRESET = 1'b0;
    got = 0;
    repeat (8) begin
      @(posedge PCLK); @(negedge PCLK);
      if (rsp_valid) got++;
    end
    chk("t5_no_rsp", got, 0);

`ifdef APB_TIMEOUT_EN
    // 6: watchdog with PREADY stuck low
    stall = 1'b1;
    issue("t6", 1'b0, 32'h10, 32'h0);
    wait_rsp("t6", 32'h10, 32'h0, 1'b1, 1'b1, 5, en);
    chk("t6_penable_cycles", en, 4);
    stall = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
